fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
- Shares the single instruction/data memory port between the IFU fetch requester (PC index/fetch path) and the LSU.
- Sits between ifu_top / LSU and the memory (DDR) interface.
- Serialises one outstanding transaction at a time.
- Gives LSU priority, with a starvation limit that protects fetch.
- Handles frontend redirect (flush) of an in-flight fetch by draining and discarding its response.

Parameters:
- ADDR_W, 64, address width of all requesters and memory port.
- STARVE_LIMIT, 4, max consecutive LSU grants while IFU is pending before IFU is forced next (range 1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  fetch request pending.
- ifu_req_addr  in  ADDR_W  fetch address (16B aligned; bits [3:0] ignored).
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_flush  in  1  redirect; kill any outstanding fetch.
- ifu_resp_valid  out  1  one-cycle fetch data valid.
- ifu_resp_data  out  128  fetched 128-bit line.
- lsu_req_valid  in  1  LSU request pending.
- lsu_req_addr  in  ADDR_W  LSU address (8B aligned).
- lsu_req_write  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  64  store data.
- lsu_req_wmask  in  8  store byte mask.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_resp_valid  out  1  one-cycle load data / store ack.
- lsu_resp_data  out  64  load data (0 for stores).
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  memory address, bits [3:0] forced 0.
- mem_req_write  out  1  write enable.
- mem_req_wdata  out  128  {wdata, wdata}.
- mem_req_wmask  out  16  wmask placed in the half selected by addr[3]; other half 0.
- mem_resp_valid  in  1  memory response / ack.
- mem_resp_data  in  128  read data.

Behaviour:
- FSM states IDLE, REQ, WAIT. Reset → IDLE; every output 0; drop flag, starve counter and owner cleared.
- IDLE, winner selection:
  - LSU wins if lsu_req_valid, unless starve_cnt == STARVE_LIMIT and ifu_req_valid (then IFU wins).
  - IFU wins if only ifu_req_valid.
  - IFU is never granted in a cycle where ifu_flush = 1.
- Grant: the winner's *_req_ready = 1 combinationally for that one cycle. The request fields and owner are latched, and the FSM moves to REQ.
- REQ:
  - mem_req_valid = 1 with latched fields, held stable until mem_req_ready.
  - Handshake moves to WAIT.
  - A request is never withdrawn once mem_req_valid is asserted.
- WAIT:
  - On mem_resp_valid, go to IDLE.
  - Next cycle, the owner's resp_valid = 1 for exactly one cycle with registered data, unless the drop flag is set.
  - A new grant is possible in the IDLE cycle after WAIT (the same cycle the response is presented).
- LSU load data = addr[3] ? mem_resp_data[127:64] : mem_resp_data[63:0]. Store: lsu_resp_valid acks, data 0.
- Minimum latency: accept at N; mem_req_valid at N+1; with mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid is at N+3.
- Flush:
  - ifu_flush while owner = IFU in REQ or WAIT sets the drop flag.
  - The transaction completes normally; ifu_resp_valid stays 0 for it.
  - The flag clears on return to IDLE.
  - ifu_flush in the same cycle as the mem_resp_valid of an IFU transaction also suppresses that response.
  - A flush has no effect on an LSU-owned transaction.
- Starve counter:
  - Increments on each LSU grant while ifu_req_valid = 1, saturating at STARVE_LIMIT.
  - Clears on IFU grant, or when ifu_req_valid = 0 in IDLE.
- mem_resp_valid in IDLE or REQ is ignored; no response is generated.
- Both ready outputs are 0 outside IDLE. Never both ready in the same cycle.
- Asynchronous reset mid-transaction: immediate return to IDLE, outputs 0; the pending memory response is lost.

Test Plan:
- Single fetch: ifu_req_valid, addr 0x8000_0010; mem ready immediate; response at +2 with data 0xA5..A5 → ifu_req_ready at cycle 0, mem_req_addr 0x8000_0010, ifu_resp_valid one cycle at cycle 3 with 0xA5..A5.
- LSU store: addr 0x1008, wdata 0x1122334455667788, wmask 0x0F → mem_req_wmask 0x0F00, mem_req_wdata = wdata replicated, lsu_resp_valid once, lsu_resp_data 0.
- LSU load addr 0x2008 with mem_resp_data upper half 0xDEADBEEF_CAFEF00D → lsu_resp_data 0xDEADBEEF_CAFEF00D.
- Starvation: both requesters valid continuously, STARVE_LIMIT 4 → grant order LSU, LSU, LSU, LSU, IFU, LSU…
- Flush in WAIT: IFU transaction outstanding, ifu_flush pulse, mem response 5 cycles later → no ifu_resp_valid; next IFU request granted in the cycle after the response.
- Reset asserted while in REQ with mem_req_ready held low → mem_req_valid drops to 0 immediately, FSM IDLE; a later mem_resp_valid is ignored.

Source files
------------

// File: rtl/fetch_mem_arbiter_if.sv
// Fetch/LSU/memory bundle seen by the shared-port arbiter.
// slave  : the arbiter's view (accepts requests, drives the memory port).
// master : the environment's view (IFU, LSU and memory model).
interface fetch_mem_arbiter_if #(
  parameter int ADDR_W = 64
);
  // IFU fetch path
  logic              ifu_req_valid;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_req_ready;
  logic              ifu_flush;
  logic              ifu_resp_valid;
  logic [127:0]      ifu_resp_data;
  // LSU path
  logic              lsu_req_valid;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_write;
  logic [63:0]       lsu_req_wdata;
  logic [7:0]        lsu_req_wmask;
  logic              lsu_req_ready;
  logic              lsu_resp_valid;
  logic [63:0]       lsu_resp_data;
  // Memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_write;
  logic [127:0]      mem_req_wdata;
  logic [15:0]       mem_req_wmask;
  logic              mem_resp_valid;
  logic [127:0]      mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_flush,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_flush,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Single-outstanding arbiter sharing one 128-bit memory port between IFU
// fetches and LSU loads/stores. LSU has priority; a starvation counter forces
// an IFU grant after STARVE_LIMIT back-to-back LSU wins. A redirect kills an
// in-flight fetch by letting it complete and dropping the response.
module fetch_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4   // 1..15
) (
  input  logic               clock,
  input  logic               reset,
  fetch_mem_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              own_ifu_q;      // 1: current transaction belongs to the IFU
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [127:0]      wdata_q;
  logic [15:0]       wmask_q;
  logic              hi_q;           // LSU word sits in the upper 64 bits
  logic              drop_q;         // in-flight fetch was redirected
  logic [3:0]        starve_q;
  logic              ifu_resp_valid_q, lsu_resp_valid_q;
  logic [127:0]      ifu_resp_data_q;
  logic [63:0]       lsu_resp_data_q;

  logic can_grant, ifu_elig, force_ifu, lsu_gnt, ifu_gnt, resp_fire, ifu_kill;

  // Low address bits are implied by alignment and never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ifu_req_addr[3:0], bus.lsu_req_addr[2:0]};

  // Winner selection; grants only happen in IDLE and never while in reset,
  // so both readys are low whenever reset is asserted.
  always_comb begin
    can_grant = (state_q == S_IDLE) && !reset;
    ifu_elig  = bus.ifu_req_valid && !bus.ifu_flush;
    // At the limit the IFU is forced; if it is blocked by a flush that cycle,
    // the LSU may still take the port rather than leave it idle.
    force_ifu = (starve_q == LIMIT) && ifu_elig;
    lsu_gnt   = can_grant && bus.lsu_req_valid && !force_ifu;
    ifu_gnt   = can_grant && ifu_elig && !lsu_gnt;
    resp_fire = (state_q == S_WAIT) && bus.mem_resp_valid;
    // A flush arriving with the response still kills the fetch data.
    ifu_kill  = drop_q || bus.ifu_flush;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lsu_gnt || ifu_gnt) state_d = S_REQ;
      S_REQ:   if (bus.mem_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request handshakes and memory request valid.
  always_comb begin
    bus.ifu_req_ready = ifu_gnt;
    bus.lsu_req_ready = lsu_gnt;
    bus.mem_req_valid = (state_q == S_REQ);
  end

  assign bus.mem_req_addr   = addr_q;
  assign bus.mem_req_write  = write_q;
  assign bus.mem_req_wdata  = wdata_q;
  assign bus.mem_req_wmask  = wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_resp_data  = ifu_resp_data_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_resp_data  = lsu_resp_data_q;

  // Latch the winner's request, shaped for the 16B memory port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_ifu_q <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      hi_q      <= 1'b0;
    end else if (lsu_gnt) begin
      own_ifu_q <= 1'b0;
      addr_q    <= {bus.lsu_req_addr[ADDR_W-1:4], 4'h0};
      write_q   <= bus.lsu_req_write;
      wdata_q   <= {bus.lsu_req_wdata, bus.lsu_req_wdata};
      wmask_q   <= bus.lsu_req_addr[3] ? {bus.lsu_req_wmask, 8'h00}
                                       : {8'h00, bus.lsu_req_wmask};
      hi_q      <= bus.lsu_req_addr[3];
    end else if (ifu_gnt) begin
      own_ifu_q <= 1'b1;
      addr_q    <= {bus.ifu_req_addr[ADDR_W-1:4], 4'h0};
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      hi_q      <= 1'b0;
    end
  end

  // Drop flag: set by a redirect against an in-flight fetch, cleared at IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 drop_q <= 1'b0;
    else if (resp_fire || state_q == S_IDLE)   drop_q <= 1'b0;
    else if (own_ifu_q && bus.ifu_flush)       drop_q <= 1'b1;
  end

  // Starvation counter: counts LSU wins the IFU had to sit through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_q <= '0;
    else if (ifu_gnt)
      starve_q <= '0;
    else if (lsu_gnt && bus.ifu_req_valid) begin
      if (starve_q != LIMIT) starve_q <= starve_q + 4'd1;
    end else if (state_q == S_IDLE && !bus.ifu_req_valid)
      starve_q <= '0;
  end

  // Register the response and steer it to the owner for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_data_q  <= '0;
    end else begin
      ifu_resp_valid_q <= resp_fire && own_ifu_q && !ifu_kill;
      lsu_resp_valid_q <= resp_fire && !own_ifu_q;
      if (resp_fire && own_ifu_q && !ifu_kill)
        ifu_resp_data_q <= bus.mem_resp_data;
      if (resp_fire && !own_ifu_q)
        lsu_resp_data_q <= write_q ? 64'h0
                         : (hi_q ? bus.mem_resp_data[127:64] : bus.mem_resp_data[63:0]);
    end
  end

  // Only one requester can ever see ready.
  a_one_ready: assert property (@(posedge clock) !(bus.ifu_req_ready && bus.lsu_req_ready));

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: inputs change on the falling edge,
// outputs are sampled 1ns later, so combinational readys and registered
// responses are both observed within the same cycle.
module tb_fetch_mem_arbiter;

  logic clock, reset;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_mem_arbiter_if #(.ADDR_W(64)) bus();

  fetch_mem_arbiter #(.ADDR_W(64), .STARVE_LIMIT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_flush      = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_write  = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  // One LSU transaction with a one-cycle stall before mem_req_ready.
  // fl holds ifu_flush high while the LSU owns the port.
  task automatic lsu_txn(input string tag, input logic [63:0] addr, input logic wr,
                         input logic [63:0] wd, input logic [7:0] wm, input logic [127:0] rdata,
                         input logic [63:0] exp_addr, input logic [15:0] exp_wm,
                         input logic [63:0] exp_rd, input logic fl);
    tick();
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = addr; bus.lsu_req_write = wr;
    bus.lsu_req_wdata = wd;   bus.lsu_req_wmask = wm;
    settle();
    chk({tag, "_rdy"}, bus.lsu_req_ready, 1);
    chk({tag, "_irdy"}, bus.ifu_req_ready, 0);
    tick();
    bus.lsu_req_valid = 1'b0; bus.lsu_req_addr = '0; bus.lsu_req_wdata = ~wd;
    bus.lsu_req_wmask = ~wm;  bus.ifu_flush = fl;
    settle();
    chk({tag, "_hold"}, bus.mem_req_valid, 1);
    tick();
    bus.mem_req_ready = 1'b1;
    settle();
    chk({tag, "_mval"}, bus.mem_req_valid, 1);
    chk({tag, "_maddr"}, bus.mem_req_addr, exp_addr);
    chk({tag, "_mwr"}, bus.mem_req_write, wr);
    chk({tag, "_mwd"}, bus.mem_req_wdata, {wd, wd});
    chk({tag, "_mwm"}, bus.mem_req_wmask, exp_wm);
    tick();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rdata;
    settle();
    chk({tag, "_early"}, bus.lsu_resp_valid, 0);
    tick();
    bus.mem_resp_valid = 1'b0; bus.ifu_flush = 1'b0;
    settle();
    chk({tag, "_rv"}, bus.lsu_resp_valid, 1);
    chk({tag, "_rd"}, bus.lsu_resp_data, exp_rd);
    tick();
    settle();
    chk({tag, "_rv1"}, bus.lsu_resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5;
    a5 = {4{32'hA5A5_A5A5}};
    // ---- reset: requests present but nothing granted, all outputs low
    reset = 1'b1;
    idle_in();
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    tick(); settle();
    chk("rst_irdy", bus.ifu_req_ready, 0);
    chk("rst_lrdy", bus.lsu_req_ready, 0);
    chk("rst_mval", bus.mem_req_valid, 0);
    chk("rst_irv",  bus.ifu_resp_valid, 0);
    chk("rst_lrv",  bus.lsu_resp_valid, 0);
    chk("rst_maddr", bus.mem_req_addr, 0);
    tick(); reset = 1'b0; idle_in(); settle();
    chk("idle_mval", bus.mem_req_valid, 0);

    // ---- single fetch, minimum latency
    tick(); bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0010; settle();
    chk("f_rdy", bus.ifu_req_ready, 1);
    chk("f_lrdy", bus.lsu_req_ready, 0);
    tick(); bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1; settle();
    chk("f_mval", bus.mem_req_valid, 1);
    chk("f_maddr", bus.mem_req_addr, 64'h8000_0010);
    chk("f_mwr", bus.mem_req_write, 0);
    tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = a5; settle();
    chk("f_mval2", bus.mem_req_valid, 0);
    chk("f_early", bus.ifu_resp_valid, 0);
    tick(); bus.mem_resp_valid = 1'b0; settle();
    chk("f_rv", bus.ifu_resp_valid, 1);
    chk("f_rd", bus.ifu_resp_data, a5);
    chk("f_lrv", bus.lsu_resp_valid, 0);
    tick(); settle();
    chk("f_rv1", bus.ifu_resp_valid, 0);

    // ---- LSU store, upper half
    lsu_txn("st", 64'h1008, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, {128{1'b1}},
            64'h1000, 16'h0F00, 64'h0, 1'b0);
    // ---- LSU load, upper half
    lsu_txn("ldh", 64'h2008, 1'b0, 64'h0, 8'h00,
            {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF},
            64'h2000, 16'h0000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    // ---- LSU load, lower half, store mask in lower half; flush ignored for LSU
    lsu_txn("ldl", 64'h3000, 1'b0, 64'h0, 8'h00,
            {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF},
            64'h3000, 16'h0000, 64'h0123_4567_89AB_CDEF, 1'b1);
    lsu_txn("stl", 64'h4010, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hC3, '0,
            64'h4010, 16'h00C3, 64'h0, 1'b0);

    // ---- starvation: both requesters always valid -> L L L L I L
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h5000;
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 64'h6000; bus.lsu_req_write = 1'b0;
      settle();
      chk($sformatf("stv_i%0d", i), bus.ifu_req_ready, (i == 4));
      chk($sformatf("stv_l%0d", i), bus.lsu_req_ready, (i != 4));
      if (i > 0) begin
        chk($sformatf("stv_irv%0d", i), bus.ifu_resp_valid, (i == 5));
        chk($sformatf("stv_lrv%0d", i), bus.lsu_resp_valid, (i != 5));
      end
      tick(); bus.mem_req_ready = 1'b1; settle();
      chk($sformatf("stv_busy%0d", i), bus.lsu_req_ready, 0);
      tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; settle();
    end
    tick(); idle_in(); settle();
    chk("stv_lrv_last", bus.lsu_resp_valid, 1);

    // ---- flush in WAIT, response 5 cycles later, then re-grant
    tick(); bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h300; settle();
    chk("fl_rdy", bus.ifu_req_ready, 1);
    tick(); bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1; settle();
    tick(); bus.mem_req_ready = 1'b0; bus.ifu_flush = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      tick(); bus.ifu_flush = 1'b0; settle();
      chk($sformatf("fl_quiet%0d", i), bus.ifu_resp_valid, 0);
    end
    tick(); bus.mem_resp_valid = 1'b1; bus.mem_resp_data = a5;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h400; settle();
    chk("fl_waitrdy", bus.ifu_req_ready, 0);
    tick(); bus.mem_resp_valid = 1'b0; settle();
    chk("fl_drop", bus.ifu_resp_valid, 0);
    chk("fl_regrant", bus.ifu_req_ready, 1);
    tick(); bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1; settle();
    chk("fl_maddr", bus.mem_req_addr, 64'h400);
    tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100; settle();
    tick(); bus.mem_resp_valid = 1'b0; settle();
    chk("fl_next_rv", bus.ifu_resp_valid, 1);
    chk("fl_next_rd", bus.ifu_resp_data, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);

    // ---- no IFU grant during flush; flush coincident with response drops it
    tick(); bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h500; bus.ifu_flush = 1'b1; settle();
    chk("fl_nogrant", bus.ifu_req_ready, 0);
    tick(); bus.ifu_flush = 1'b0; settle();
    chk("fl_grant", bus.ifu_req_ready, 1);
    tick(); bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1; settle();
    tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.ifu_flush = 1'b1; settle();
    tick(); idle_in(); settle();
    chk("fl_same", bus.ifu_resp_valid, 0);

    // ---- async reset while stalled in REQ
    tick(); bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 64'h7000; settle();
    chk("ar_rdy", bus.lsu_req_ready, 1);
    tick(); bus.lsu_req_valid = 1'b0; settle();
    chk("ar_mval", bus.mem_req_valid, 1);
    #1 reset = 1'b1;
    #1 chk("ar_drop", bus.mem_req_valid, 0);
    tick(); reset = 1'b0; bus.mem_resp_valid = 1'b1; settle();
    chk("ar_idle", bus.mem_req_valid, 0);
    tick(); bus.mem_resp_valid = 1'b0; bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h800; settle();
    chk("ar_lrv", bus.lsu_resp_valid, 0);
    chk("ar_irv", bus.ifu_resp_valid, 0);
    chk("ar_regrant", bus.ifu_req_ready, 1);
    tick(); idle_in(); settle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
